// File: rtl/riscv_test_pkg.sv
// Shared definitions for the riscv-tests pass/fail monitor: FSM encoding,
// default register indices and RISC-V ABI register numbers.
package riscv_test_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SETTLE = 3'd1,
    ST_PASS   = 3'd2,
    ST_FAIL   = 3'd3,
    ST_TMO    = 3'd4
  } state_e;

  localparam int unsigned ABI_ZERO = 0;
  localparam int unsigned ABI_RA   = 1;
  localparam int unsigned ABI_SP   = 2;
  localparam int unsigned ABI_GP   = 3;
  localparam int unsigned ABI_S10  = 26;
  localparam int unsigned ABI_S11  = 27;

  localparam int unsigned DEF_DONE_REG = ABI_S10;
  localparam int unsigned DEF_PASS_REG = ABI_S11;
  localparam int unsigned DEF_TNUM_REG = ABI_GP;

  localparam int unsigned SETTLE_W = 8;

  function automatic logic is_terminal(input state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TMO);
  endfunction

endpackage

// File: rtl/riscv_test_hist_buf.sv
// Ring buffer of the most recent register-file writes; read index 0 is the
// newest entry. Only built when RISCV_TEST_MONITOR_HIST_EN is defined.
module riscv_test_hist_buf #(
  parameter  int unsigned ADDR_W = 5,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr_c,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [IDX_W-1:0]  wptr;
  logic [IDX_W-1:0]  rptr;

  // Cleared entries read back as zero until overwritten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else if (clr) begin
      wptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_data[i] <= '0;
      end
    end else if (wr_en) begin
      mem_addr[wptr] <= wr_addr;
      mem_data[wptr] <= wr_data;
      wptr           <= wptr + IDX_W'(1);
    end
  end

  assign rptr      = wptr - IDX_W'(1) - rd_idx;
  assign rd_addr_c = mem_addr[rptr];
  assign rd_data_c = mem_data[rptr];

endmodule

// File: rtl/riscv_test_monitor.sv
// Snoops register-file writes of a riscv-tests program and reports PASS/FAIL/TIMEOUT.
// Define RISCV_TEST_MONITOR_HIST_EN to build the write-history ring buffer.
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter  int unsigned DATA_W         = 32,
  parameter  int unsigned ADDR_W         = 5,
  parameter  int unsigned DONE_REG       = DEF_DONE_REG,
  parameter  int unsigned PASS_REG       = DEF_PASS_REG,
  parameter  int unsigned TNUM_REG       = DEF_TNUM_REG,
  parameter  int unsigned SETTLE_CYCLES  = 10,
  parameter  int unsigned TIMEOUT_CYCLES = 100000,
  parameter  int unsigned HIST_DEPTH     = 8,
  localparam int unsigned HIST_IDX_W     = $clog2(HIST_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  wb_we,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [DATA_W-1:0]     fail_testnum,
  output logic [31:0]           cycle_count,
  input  logic [HIST_IDX_W-1:0] hist_idx,
  output logic [ADDR_W-1:0]     hist_addr,
  output logic [DATA_W-1:0]     hist_data
);

  localparam logic [31:0]         TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  state_e              state, state_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [DATA_W-1:0]   pass_sh, pass_sh_nxt;
  logic [DATA_W-1:0]   tnum_sh, tnum_sh_nxt;
  logic                active;
  logic                cap;
  logic                done_hit;
  logic                enter_term;

  assign active      = (state == ST_RUN) || (state == ST_SETTLE);
  assign cap         = active && wb_we && (wb_addr != '0);
  assign done_hit    = cap && (wb_addr == ADDR_W'(DONE_REG)) && (wb_data == DATA_W'(1));
  assign pass_sh_nxt = (cap && (wb_addr == ADDR_W'(PASS_REG))) ? wb_data : pass_sh;
  assign tnum_sh_nxt = (cap && (wb_addr == ADDR_W'(TNUM_REG))) ? wb_data : tnum_sh;
  assign enter_term  = active && is_terminal(state_nxt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // Done beats timeout in RUN; the settle verdict sees a PASS_REG write in its last cycle.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      ST_RUN: begin
        if (done_hit) begin
          state_nxt  = ST_SETTLE;
          settle_nxt = SETTLE_LOAD;
        end else if ((TIMEOUT_CYCLES != 0) && (cycle_count == TMO_LAST)) begin
          state_nxt = ST_TMO;
        end
      end
      ST_SETTLE: begin
        settle_nxt = settle_cnt - SETTLE_W'(1);
        if (settle_cnt == SETTLE_W'(1))
          state_nxt = (pass_sh_nxt == DATA_W'(1)) ? ST_PASS : ST_FAIL;
      end
      default: ;
    endcase
    if (restart) state_nxt = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt   <= '0;
      pass_sh      <= '0;
      tnum_sh      <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else if (restart) begin
      settle_cnt   <= '0;
      pass_sh      <= '0;
      tnum_sh      <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else begin
      settle_cnt <= settle_nxt;
      pass_sh    <= pass_sh_nxt;
      tnum_sh    <= tnum_sh_nxt;
      if (active && !enter_term && (cycle_count != '1))
        cycle_count <= cycle_count + 32'd1;
      if (enter_term) begin
        done         <= 1'b1;
        pass         <= (state_nxt == ST_PASS);
        fail         <= (state_nxt == ST_FAIL);
        timeout      <= (state_nxt == ST_TMO);
        fail_testnum <= tnum_sh;
      end
    end
  end

`ifdef RISCV_TEST_MONITOR_HIST_EN
  riscv_test_hist_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clr       (restart),
    .wr_en     (cap),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_idx    (hist_idx),
    .rd_addr_c (hist_addr),
    .rd_data_c (hist_data)
  );
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_idx;
  assign hist_addr       = '0;
  assign hist_data       = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: directed and random runs checked
// against a schedule-level reference model.
module tb_riscv_test_monitor;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int SETTLE = 10;
  localparam int TMO    = 100;
  localparam int HD     = 8;
  localparam int HIW    = 3;
  localparam int MAXL   = 128;

  logic           clk      = 1'b0;
  logic           rst      = 1'b0;
  logic           restart  = 1'b0;
  logic           wb_we    = 1'b0;
  logic [AW-1:0]  wb_addr  = '0;
  logic [DW-1:0]  wb_data  = '0;
  logic [HIW-1:0] hist_idx = '0;
  logic           done, pass, fail, timeout;
  logic [DW-1:0]  fail_testnum;
  logic [31:0]    cycle_count;
  logic [AW-1:0]  hist_addr;
  logic [DW-1:0]  hist_data;

  always #5 clk = ~clk;

  riscv_test_monitor #(
    .DATA_W(DW), .ADDR_W(AW), .DONE_REG(26), .PASS_REG(27), .TNUM_REG(3),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .HIST_DEPTH(HD)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_testnum(fail_testnum), .cycle_count(cycle_count),
    .hist_idx(hist_idx), .hist_addr(hist_addr), .hist_data(hist_data)
  );

  // kind: 0 pass, 1 fail, 2 timeout; vcyc is the run cycle whose edge registers the verdict
  typedef struct {
    int            kind;
    logic [DW-1:0] tnum;
    int            ccount;
    int            vcyc;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc    = -1;
  logic          done_q = 1'b0;

  bit            s_we   [MAXL];
  logic [AW-1:0] s_addr [MAXL];
  logic [DW-1:0] s_data [MAXL];
  logic [AW-1:0] m_ha   [HD];
  logic [DW-1:0] m_hd   [HD];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every rising verdict consumes one scoreboard entry.
  always @(negedge clk) begin
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_verdict actual=done required=no_verdict cycle=%0d", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("mon_pass",     pass,         mon_e.kind == 0);
        chk("mon_fail",     fail,         mon_e.kind == 1);
        chk("mon_timeout",  timeout,      mon_e.kind == 2);
        chk("mon_testnum",  fail_testnum, mon_e.tnum);
        chk("mon_cycles",   cycle_count,  mon_e.ccount);
        chk("mon_latency",  cyc,          mon_e.vcyc + 1);
      end
    end
    done_q = done;
  end

  task automatic clear_sched();
    for (int k = 0; k < MAXL; k++) begin
      s_we[k]   = 1'b0;
      s_addr[k] = AW'($urandom);
      s_data[k] = $urandom;
    end
  endtask

  task automatic put(input int k, input int a, input logic [DW-1:0] d);
    s_we[k]   = 1'b1;
    s_addr[k] = AW'(a);
    s_data[k] = d;
  endtask

  task automatic rand_fill(input int pct);
    for (int k = 0; k < MAXL; k++) begin
      if (int'($urandom_range(99)) < pct) begin
        int            a;
        logic [DW-1:0] d;
        d = $urandom;
        case ($urandom_range(5))
          0:       a = 0;
          1:       a = 3;
          2:       a = 27;
          3:       a = 26;
          4:       a = 5;
          default: a = int'($urandom_range(1, 31));
        endcase
        if (a == 27 && $urandom_range(1) == 1) d = 1;
        if (a == 26 && d == 1) d = 2;
        put(k, a, d);
      end
    end
  endtask

  // Reference: first x26==1 write ends the run (verdict SETTLE cycles later), else timeout.
  task automatic model(output exp_t e);
    int            v;
    int            kind;
    logic [DW-1:0] p27;
    logic [DW-1:0] tn;
    logic [AW-1:0] qa[$];
    logic [DW-1:0] qd[$];
    v    = TMO - 1;
    kind = 2;
    p27  = '0;
    tn   = '0;
    for (int k = 0; k < TMO; k++) begin
      if (s_we[k] && s_addr[k] == AW'(26) && s_data[k] == DW'(1)) begin
        v    = k + SETTLE;
        kind = 0;
        break;
      end
    end
    for (int k = 0; k <= v; k++) begin
      if (s_we[k] && s_addr[k] != '0) begin
        qa.push_back(s_addr[k]);
        qd.push_back(s_data[k]);
        if (s_addr[k] == AW'(27)) p27 = s_data[k];
        if (s_addr[k] == AW'(3) && k < v) tn = s_data[k];
      end
    end
    if (kind != 2) kind = (p27 == DW'(1)) ? 0 : 1;
    e.kind   = kind;
    e.tnum   = tn;
    e.ccount = v;
    e.vcyc   = v;
    for (int i = 0; i < HD; i++) begin
      if (i < qa.size()) begin
        m_ha[i] = qa[qa.size() - 1 - i];
        m_hd[i] = qd[qd.size() - 1 - i];
      end else begin
        m_ha[i] = '0;
        m_hd[i] = '0;
      end
    end
  endtask

  task automatic drive(input int k);
    cyc     = k;
    wb_we   = s_we[k];
    wb_addr = s_addr[k];
    wb_data = s_data[k];
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"},    done,         0);
    chk({tag, "_pass"},    pass,         0);
    chk({tag, "_fail"},    fail,         0);
    chk({tag, "_timeout"}, timeout,      0);
    chk({tag, "_testnum"}, fail_testnum, 0);
    chk({tag, "_cycles"},  cycle_count,  0);
  endtask

  task automatic check_hist(input string tag, input bit expect_empty);
`ifdef RISCV_TEST_MONITOR_HIST_EN
    for (int i = 0; i < HD; i++) begin
      hist_idx = HIW'(i);
      #1;
      chk({tag, "_hist_addr"}, hist_addr, expect_empty ? 0 : 64'(m_ha[i]));
      chk({tag, "_hist_data"}, hist_data, expect_empty ? 0 : 64'(m_hd[i]));
    end
`else
    hist_idx = HIW'($urandom);
    #1;
    chk({tag, "_hist_addr"}, hist_addr, 0);
    chk({tag, "_hist_data"}, hist_data, 0);
    if (expect_empty) hist_idx = '0;
`endif
  endtask

  // Restart carries a PASS_REG write of 1 that must be discarded.
  task automatic do_restart(input string tag);
    cyc     = -1;
    restart = 1'b1;
    wb_we   = 1'b1;
    wb_addr = AW'(27);
    wb_data = DW'(1);
    @(posedge clk);
    #1;
    restart = 1'b0;
    wb_we   = 1'b0;
    check_zero({tag, "_restart"});
  endtask

  task automatic do_run(input string tag);
    exp_t e;
    int   v;
    model(e);
    v = e.vcyc;
    if (s_we[v] && s_addr[v] == AW'(3)) s_addr[v] = AW'(5);
    model(e);
    sbq.push_back(e);
    for (int k = 0; k <= v + 3; k++) begin
      drive(k);
      @(posedge clk);
      #1;
    end
    wb_we = 1'b0;
    chk({tag, "_verdict_pending"}, sbq.size(), 0);
    sbq.delete();
    chk({tag, "_sticky_done"},    done,         1);
    chk({tag, "_sticky_pass"},    pass,         e.kind == 0);
    chk({tag, "_sticky_fail"},    fail,         e.kind == 1);
    chk({tag, "_sticky_timeout"}, timeout,      e.kind == 2);
    chk({tag, "_sticky_testnum"}, fail_testnum, e.tnum);
    chk({tag, "_frozen_cycles"},  cycle_count,  e.ccount);
    check_hist(tag, 1'b0);
    do_restart(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    check_hist("reset", 1'b1);
    rst = 1'b1;

    clear_sched(); put(2, 3, 5); put(5, 27, 1); put(40, 26, 1);
    do_run("pass");

    clear_sched(); put(2, 3, 7); put(6, 27, 0); put(40, 26, 1); put(51, 27, 1); put(52, 3, 99);
    do_run("fail");

    clear_sched(); put(4, 3, 9); put(20, 26, 1);
    do_run("restart_discard");

    clear_sched(); put(2, 3, 12); put(5, 27, 0); put(10, 0, 1); put(15, 26, 2);
    put(40, 26, 1); put(50, 27, 1);
    do_run("late_pass");

    clear_sched(); put(3, 3, 4); put(30, 26, 3); put(31, 0, 1);
    do_run("timeout");

    clear_sched(); put(60, 27, 1); put(70, 3, 8); put(99, 26, 1);
    do_run("collision");

    // Asynchronous reset in the middle of the settle window.
    clear_sched(); put(3, 3, 11); put(40, 26, 1);
    for (int k = 0; k < 45; k++) begin
      drive(k);
      @(posedge clk);
      #1;
    end
    drive(45);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    wb_we = 1'b0;
    cyc   = -1;
    @(posedge clk);
    #1;
    check_zero("async_rst_hold");
    check_hist("async_rst", 1'b1);
    rst = 1'b1;

    clear_sched();
    for (int k = 1; k <= 10; k++) put(k, 5, DW'(k));
    put(20, 26, 1);
    do_run("hist_wrap");

    for (int r = 0; r < 16; r++) begin
      clear_sched();
      rand_fill(30);
      if ($urandom_range(4) != 0) put(int'($urandom_range(0, 99)), 26, 1);
      do_run($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
